tune_sequencer: RTL and testbench

- Note sequencer that drives one triangle oscillator.
- Holds a small writable note table; each entry is an oscillator inverse-slope (pitch) plus a duration.
- Steps through the table, presents each pitch on invslope, gates the oscillator, inserts inter-note gaps, and reports completion.
- Sits between the host/config logic and the oscillator's invslope and reset inputs.

---
 rtl/tune_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_tune_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tune_sequencer.sv
// Note sequencer for a triangle oscillator: plays a writable pitch/duration table with gaps.
// Optional TUNE_SEQ_LOOP_EN adds a loop input that restarts the table instead of finishing.
module tune_sequencer #(
    parameter int unsigned CTR_SIZE  = 8,
    parameter int unsigned DUR_W     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned TICK_DIV  = 1000,
    parameter int unsigned GAP_TICKS = 1,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [CTR_SIZE+DUR_W-1:0] wr_data,
    input  logic                      start,
    input  logic                      stop,
    output logic [CTR_SIZE-1:0]       invslope,
    output logic                      osc_rst,
    output logic                      gate,
    output logic                      busy,
    output logic                      done,
    output logic [AW-1:0]             note_idx
`ifdef TUNE_SEQ_LOOP_EN
    ,
    input  logic                      loop
`endif
);

    localparam int unsigned EW = CTR_SIZE + DUR_W;
    localparam int unsigned PW = $clog2(TICK_DIV + 1);
    localparam int unsigned GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] IDX_LAST   = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StPlay,
        StGap,
        StFinish
    } state_e;

    state_e               state_q;
    logic [EW-1:0]        table_mem [DEPTH];
    logic [EW-1:0]        rd_q;
    logic [PW-1:0]        presc_q;
    logic [DUR_W-1:0]     dur_cnt_q;
    logic [GW-1:0]        gap_cnt_q;

    logic [CTR_SIZE-1:0]  rd_slope;
    logic [DUR_W-1:0]     rd_dur;
    logic                 tick_wrap;
    logic                 last_note;
    logic                 note_done;
    logic                 end_marker;
    logic                 seq_end;
    logic                 restart;
    logic                 loop_req;

`ifdef TUNE_SEQ_LOOP_EN
    assign loop_req = loop;
`else
    assign loop_req = 1'b0;
`endif

    assign rd_slope   = rd_q[CTR_SIZE-1:0];
    assign rd_dur     = rd_q[EW-1:CTR_SIZE];
    assign tick_wrap  = (presc_q == PRESC_LAST);
    assign last_note  = (note_idx == IDX_LAST);
    assign end_marker = (state_q == StLoad) && (rd_dur == '0);

    // A note completes either at the end of its gap, or at the end of PLAY when gaps are disabled.
    assign note_done = ((state_q == StPlay) && tick_wrap && (dur_cnt_q == DUR_W'(1))
                        && (GAP_TICKS == 0))
                     || ((state_q == StGap) && tick_wrap && (gap_cnt_q == GW'(1)));
    assign seq_end   = end_marker || (note_done && last_note);
    // An end marker at entry 0 would loop forever, so it always finishes.
    assign restart   = seq_end && loop_req && !(end_marker && (note_idx == '0));

    always_ff @(posedge clk) begin
        if (wr_en && (state_q == StIdle)) begin
            table_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            rd_q      <= '0;
            presc_q   <= '0;
            dur_cnt_q <= '0;
            gap_cnt_q <= '0;
            invslope  <= '0;
            osc_rst   <= 1'b1;
            gate      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            note_idx  <= '0;
        end else if (stop && (state_q != StIdle)) begin
            state_q  <= StIdle;
            invslope <= '0;
            osc_rst  <= 1'b1;
            gate     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            note_idx <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !stop) begin
                        state_q  <= StFetch;
                        note_idx <= '0;
                        busy     <= 1'b1;
                    end
                end
                StFetch: begin
                    rd_q    <= table_mem[note_idx];
                    state_q <= StLoad;
                end
                StLoad: begin
                    if (rd_dur != '0) begin
                        invslope  <= rd_slope;
                        dur_cnt_q <= rd_dur;
                        presc_q   <= '0;
                        gate      <= (rd_slope != '0);
                        osc_rst   <= (rd_slope == '0);
                        state_q   <= StPlay;
                    end
                end
                StPlay: begin
                    presc_q <= tick_wrap ? '0 : presc_q + PW'(1);
                    if (tick_wrap) begin
                        dur_cnt_q <= dur_cnt_q - DUR_W'(1);
                        if (dur_cnt_q == DUR_W'(1)) begin
                            gate    <= 1'b0;
                            osc_rst <= 1'b1;
                            if (GAP_TICKS > 0) begin
                                gap_cnt_q <= GW'(GAP_TICKS);
                                state_q   <= StGap;
                            end
                        end
                    end
                end
                StGap: begin
                    presc_q <= tick_wrap ? '0 : presc_q + PW'(1);
                    if (tick_wrap) begin
                        gap_cnt_q <= gap_cnt_q - GW'(1);
                    end
                end
                StFinish: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            // Note/sequence completion overrides the per-state next-state above.
            if (note_done && !last_note) begin
                note_idx <= note_idx + AW'(1);
                state_q  <= StFetch;
            end
            if (seq_end) begin
                if (restart) begin
                    note_idx <= '0;
                    state_q  <= StFetch;
                end else begin
                    state_q  <= StFinish;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    gate     <= 1'b0;
                    osc_rst  <= 1'b1;
                    invslope <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tune_sequencer.sv
// Directed self-checking bench for tune_sequencer (TICK_DIV=4, GAP_TICKS=1, DEPTH=4).
module tb_tune_sequencer;

    localparam int unsigned CTR_SIZE  = 8;
    localparam int unsigned DUR_W     = 8;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned GAP_TICKS = 1;
    localparam int unsigned AW        = 2;

    typedef struct {
        integer len;
        integer gate;
        integer osc;
        integer inv;
        integer busy;
        integer done;
        integer idx;
    } seg_t;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      wr_en = 1'b0;
    logic [AW-1:0]             wr_addr = '0;
    logic [CTR_SIZE+DUR_W-1:0] wr_data = '0;
    logic                      start = 1'b0;
    logic                      stop = 1'b0;
    logic [CTR_SIZE-1:0]       invslope;
    logic                      osc_rst;
    logic                      gate;
    logic                      busy;
    logic                      done;
    logic [AW-1:0]             note_idx;
`ifdef TUNE_SEQ_LOOP_EN
    logic                      loop = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tune_sequencer #(
        .CTR_SIZE (CTR_SIZE),
        .DUR_W    (DUR_W),
        .DEPTH    (DEPTH),
        .TICK_DIV (TICK_DIV),
        .GAP_TICKS(GAP_TICKS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .stop    (stop),
        .invslope(invslope),
        .osc_rst (osc_rst),
        .gate    (gate),
        .busy    (busy),
        .done    (done),
        .note_idx(note_idx)
`ifdef TUNE_SEQ_LOOP_EN
        ,
        .loop    (loop)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input int slope, input int dur);
        wr_en   = 1'b1;
        wr_addr = addr[AW-1:0];
        wr_data = {dur[DUR_W-1:0], slope[CTR_SIZE-1:0]};
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if ({invslope, osc_rst, gate, busy, done, note_idx} !== {8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL reset_held: got inv=%0d osc=%b gate=%b busy=%b done=%b idx=%0d",
                     invslope, osc_rst, gate, busy, done, note_idx);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({invslope, osc_rst, gate, busy, done, note_idx} !== {8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL reset_release: got inv=%0d osc=%b gate=%b busy=%b done=%b idx=%0d",
                     invslope, osc_rst, gate, busy, done, note_idx);
        end
        write_entry(0, 50, 4);
        write_entry(1, 0, 0);
        pulse_start();
        tick();
        tick();
        tick();
        total++;
        if ({gate, invslope} !== {1'b1, 8'd50}) begin
            bad++;
            $display("FAIL reset_preplay: got gate=%b inv=%0d want gate=1 inv=50", gate, invslope);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({invslope, osc_rst, gate, busy, done, note_idx} !== {8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL reset_async: got inv=%0d osc=%b gate=%b busy=%b done=%b idx=%0d",
                     invslope, osc_rst, gate, busy, done, note_idx);
        end
        tick();
        rst = 1'b1;
        begin
            int seen_done = 0;
            for (int i = 0; i < 30; i++) begin
                tick();
                if (done === 1'b1 || busy === 1'b1) seen_done++;
            end
            total++;
            if (seen_done != 0) begin
                bad++;
                $display("FAIL reset_no_done: got %0d active cycles want 0", seen_done);
            end
        end
    endtask

    task automatic test_three_notes();
        seg_t segs[13] = '{
            '{1, 0, 1, 0, 1, 0, 0}, '{1, 0, 1, 0, 1, 0, 0},
            '{8, 1, 0, 10, 1, 0, 0}, '{4, 0, 1, 10, 1, 0, 0},
            '{2, 0, 1, 10, 1, 0, 1}, '{4, 0, 1, 0, 1, 0, 1},
            '{4, 0, 1, 0, 1, 0, 1}, '{2, 0, 1, 0, 1, 0, 2},
            '{12, 1, 0, 20, 1, 0, 2}, '{4, 0, 1, 20, 1, 0, 2},
            '{2, 0, 1, 20, 1, 0, 3}, '{1, 0, 1, 0, 0, 1, -1},
            '{2, 0, 1, 0, 0, 0, -1}
        };
        write_entry(0, 10, 2);
        write_entry(1, 0, 1);
        write_entry(2, 20, 3);
        write_entry(3, 77, 0);
        pulse_start();
        for (int s = 0; s < 13; s++) begin
            for (int c = 0; c < segs[s].len; c++) begin
                total++;
                if ({integer'(gate), integer'(osc_rst), integer'(invslope), integer'(busy),
                     integer'(done)} !== {segs[s].gate, segs[s].osc, segs[s].inv, segs[s].busy,
                     segs[s].done}) begin
                    bad++;
                    $display("FAIL three_notes seg%0d cyc%0d: got gate=%b osc=%b inv=%0d busy=%b done=%b want %0d %0d %0d %0d %0d",
                             s, c, gate, osc_rst, invslope, busy, done, segs[s].gate,
                             segs[s].osc, segs[s].inv, segs[s].busy, segs[s].done);
                end
                if (segs[s].idx >= 0) begin
                    total++;
                    if (integer'(note_idx) !== segs[s].idx) begin
                        bad++;
                        $display("FAIL three_notes_idx seg%0d cyc%0d: got %0d want %0d",
                                 s, c, note_idx, segs[s].idx);
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_full_table();
        seg_t segs[14] = '{
            '{2, 0, 1, 0, 1, 0, 0}, '{4, 1, 0, 5, 1, 0, 0}, '{4, 0, 1, 5, 1, 0, 0},
            '{2, 0, 1, 5, 1, 0, 1}, '{4, 1, 0, 6, 1, 0, 1}, '{4, 0, 1, 6, 1, 0, 1},
            '{2, 0, 1, 6, 1, 0, 2}, '{4, 1, 0, 7, 1, 0, 2}, '{4, 0, 1, 7, 1, 0, 2},
            '{2, 0, 1, 7, 1, 0, 3}, '{4, 1, 0, 8, 1, 0, 3}, '{4, 0, 1, 8, 1, 0, 3},
            '{1, 0, 1, 0, 0, 1, -1}, '{2, 0, 1, 0, 0, 0, -1}
        };
        for (int i = 0; i < 4; i++) write_entry(i, 5 + i, 1);
        pulse_start();
        for (int s = 0; s < 14; s++) begin
            for (int c = 0; c < segs[s].len; c++) begin
                total++;
                if ({integer'(gate), integer'(osc_rst), integer'(invslope), integer'(busy),
                     integer'(done)} !== {segs[s].gate, segs[s].osc, segs[s].inv, segs[s].busy,
                     segs[s].done}) begin
                    bad++;
                    $display("FAIL full_table seg%0d cyc%0d: got gate=%b osc=%b inv=%0d busy=%b done=%b want %0d %0d %0d %0d %0d",
                             s, c, gate, osc_rst, invslope, busy, done, segs[s].gate,
                             segs[s].osc, segs[s].inv, segs[s].busy, segs[s].done);
                end
                if (segs[s].idx >= 0) begin
                    total++;
                    if (integer'(note_idx) !== segs[s].idx) begin
                        bad++;
                        $display("FAIL full_table_idx seg%0d cyc%0d: got %0d want %0d",
                                 s, c, note_idx, segs[s].idx);
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_stop();
        int active;
        write_entry(0, 10, 2);
        write_entry(1, 30, 2);
        write_entry(2, 0, 0);
        pulse_start();
        for (int i = 0; i < 18; i++) tick();
        total++;
        if ({note_idx, gate, invslope} !== {2'd1, 1'b1, 8'd30}) begin
            bad++;
            $display("FAIL stop_pre: got idx=%0d gate=%b inv=%0d want 1 1 30", note_idx, gate, invslope);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total++;
        if ({busy, gate, osc_rst, invslope, note_idx, done} !== {1'b0, 1'b0, 1'b1, 8'd0, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL stop_abort: got busy=%b gate=%b osc=%b inv=%0d idx=%0d done=%b",
                     busy, gate, osc_rst, invslope, note_idx, done);
        end
        active = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) active++;
        end
        total++;
        if (active != 0) begin
            bad++;
            $display("FAIL stop_quiet: got %0d active cycles want 0", active);
        end
        stop = 1'b1;
        start = 1'b1;
        tick();
        total++;
        if ({busy, gate} !== 2'b00) begin
            bad++;
            $display("FAIL stop_start_idle: got busy=%b gate=%b want 0 0", busy, gate);
        end
        stop = 1'b0;
        start = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL stop_start_idle2: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_busy_writes();
        int n;
        write_entry(0, 10, 2);
        write_entry(1, 0, 1);
        write_entry(2, 20, 3);
        write_entry(3, 77, 0);
        pulse_start();
        for (int i = 0; i < 4; i++) tick();
        wr_en   = 1'b1;
        wr_addr = 2'd0;
        wr_data = {8'd5, 8'd99};
        tick();
        wr_en = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if ({note_idx, busy} !== {2'd1, 1'b1}) begin
            bad++;
            $display("FAIL busy_start_ignored: got idx=%0d busy=%b want 1 1", note_idx, busy);
        end
        for (int i = 0; i < 200 && done !== 1'b1; i++) tick();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL busy_first_done: got done=%b want 1 within bound", done);
        end
        tick();
        pulse_start();
        tick();
        tick();
        total++;
        if ({invslope, gate} !== {8'd10, 1'b1}) begin
            bad++;
            $display("FAIL busy_replay_val: got inv=%0d gate=%b want 10 1", invslope, gate);
        end
        n = 0;
        while (gate === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL busy_replay_len: got %0d gate cycles want 8", n);
        end
        for (int i = 0; i < 200 && done !== 1'b1; i++) tick();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL busy_replay_done: got done=%b want 1 within bound", done);
        end
        tick();
    endtask

`ifdef TUNE_SEQ_LOOP_EN
    task automatic test_loop();
        int seen1;
        int wrapped;
        int errs;
        write_entry(0, 10, 1);
        write_entry(1, 20, 1);
        write_entry(2, 0, 0);
        loop = 1'b1;
        pulse_start();
        seen1 = 0;
        wrapped = 0;
        errs = 0;
        for (int i = 0; i < 60; i++) begin
            if (note_idx === 2'd1) seen1 = 1;
            if (seen1 == 1 && note_idx === 2'd0) wrapped = 1;
            if (done !== 1'b0 || busy !== 1'b1) errs++;
            tick();
        end
        total++;
        if ({wrapped, errs} !== {32'd1, 32'd0}) begin
            bad++;
            $display("FAIL loop_wrap: got wrapped=%0d bad_cycles=%0d want 1 0", wrapped, errs);
        end
        loop = 1'b0;
        for (int i = 0; i < 100 && done !== 1'b1; i++) tick();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL loop_drop_done: got done=%b want 1 within bound", done);
        end
        tick();
        write_entry(0, 10, 0);
        loop = 1'b1;
        pulse_start();
        for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL loop_marker0_done: got done=%b want 1 within bound", done);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL loop_marker0_idle: got busy=%b want 0", busy);
        end
        loop = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_three_notes();
        test_full_table();
        test_stop();
        test_busy_writes();
`ifdef TUNE_SEQ_LOOP_EN
        test_loop();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
